// File: rtl/wb_bridge_arbiter.sv
// Two-port Wishbone B4 Classic arbiter in front of a shared WB-to-AXI-Lite bridge.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bridge_arbiter #(
    parameter  int unsigned WB_ADR_WIDTH   = 29,
    parameter  int unsigned DATA_WIDTH     = 64,
    parameter  int unsigned TIMEOUT_CYCLES = 1024,
    localparam int unsigned SEL_WIDTH      = DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s0_cyc,
    input  logic                    s0_stb,
    input  logic                    s0_we,
    input  logic [WB_ADR_WIDTH-1:0] s0_adr,
    input  logic [DATA_WIDTH-1:0]   s0_dat_i,
    input  logic [SEL_WIDTH-1:0]    s0_sel,
    output logic [DATA_WIDTH-1:0]   s0_dat_o,
    output logic                    s0_ack,
    output logic                    s0_stall,
    input  logic                    s1_cyc,
    input  logic                    s1_stb,
    input  logic                    s1_we,
    input  logic [WB_ADR_WIDTH-1:0] s1_adr,
    input  logic [DATA_WIDTH-1:0]   s1_dat_i,
    input  logic [SEL_WIDTH-1:0]    s1_sel,
    output logic [DATA_WIDTH-1:0]   s1_dat_o,
    output logic                    s1_ack,
    output logic                    s1_stall,
    output logic                    m_cyc,
    output logic                    m_stb,
    output logic                    m_we,
    output logic [WB_ADR_WIDTH-1:0] m_adr,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic [SEL_WIDTH-1:0]    m_sel,
    input  logic [DATA_WIDTH-1:0]   m_dat_i,
    input  logic                    m_ack
);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t state, state_nxt;
    logic   last_grant;   // also identifies the current owner while GRANT/DRAIN
    logic   req0, req1, any_req, grant_sel, own_cyc, tmo_fire, ack_now;
    logic [DATA_WIDTH-1:0] resp_data;

    assign req0      = s0_cyc & s0_stb;
    assign req1      = s1_cyc & s1_stb;
    assign any_req   = req0 | req1;
    assign grant_sel = (req0 & req1) ? ~last_grant : req1;
    assign own_cyc   = last_grant ? s1_cyc : s0_cyc;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] tmo_cnt;

    // Counts GRANT cycles without a bridge response; idle states keep it cleared
    always_ff @(posedge aclk) begin
        if (!aresetn)
            tmo_cnt <= '0;
        else if (state != GRANT)
            tmo_cnt <= '0;
        else if (!m_ack)
            tmo_cnt <= tmo_cnt + CNT_W'(1);
    end

    // A real m_ack or an owner abort in the same cycle takes precedence
    assign tmo_fire = (state == GRANT) && !m_ack && own_cyc &&
                      (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT: begin
                if (m_ack)
                    state_nxt = IDLE;
                else if (!own_cyc || tmo_fire)
                    state_nxt = DRAIN;
            end
            DRAIN:   if (m_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Master-side request is captured once at grant and held for the transfer
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            last_grant <= 1'b1;
            m_cyc      <= 1'b0;
            m_stb      <= 1'b0;
            m_we       <= 1'b0;
            m_adr      <= '0;
            m_dat_o    <= '0;
            m_sel      <= '0;
        end else begin
            m_cyc <= (state_nxt != IDLE);
            m_stb <= (state_nxt == GRANT);
            if (state == IDLE && any_req) begin
                last_grant <= grant_sel;
                m_we       <= grant_sel ? s1_we    : s0_we;
                m_adr      <= grant_sel ? s1_adr   : s0_adr;
                m_dat_o    <= grant_sel ? s1_dat_i : s0_dat_i;
                m_sel      <= grant_sel ? s1_sel   : s0_sel;
            end
        end
    end

    assign ack_now   = aresetn && (state == GRANT) && (m_ack || tmo_fire);
    assign resp_data = m_ack ? m_dat_i : '1;

    assign s0_ack   = ack_now & ~last_grant;
    assign s1_ack   = ack_now & last_grant;
    assign s0_dat_o = s0_ack ? resp_data : '0;
    assign s1_dat_o = s1_ack ? resp_data : '0;
    assign s0_stall = aresetn & req0 & ~s0_ack;
    assign s1_stall = aresetn & req1 & ~s1_ack;

endmodule

// File: tb/tb_wb_bridge_arbiter.sv
// Directed self-checking bench for wb_bridge_arbiter (arbitration, drain, reset, optional watchdog).
module tb_wb_bridge_arbiter;

    logic        aclk;
    logic        aresetn;
    logic        s0_cyc, s0_stb, s0_we, s0_ack, s0_stall;
    logic [28:0] s0_adr;
    logic [63:0] s0_dat_i, s0_dat_o;
    logic [7:0]  s0_sel;
    logic        s1_cyc, s1_stb, s1_we, s1_ack, s1_stall;
    logic [28:0] s1_adr;
    logic [63:0] s1_dat_i, s1_dat_o;
    logic [7:0]  s1_sel;
    logic        m_cyc, m_stb, m_we, m_ack;
    logic [28:0] m_adr;
    logic [63:0] m_dat_o, m_dat_i;
    logic [7:0]  m_sel;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    wb_bridge_arbiter #(
        .WB_ADR_WIDTH  (29),
        .DATA_WIDTH    (64),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_cyc(s0_cyc), .s0_stb(s0_stb), .s0_we(s0_we), .s0_adr(s0_adr),
        .s0_dat_i(s0_dat_i), .s0_sel(s0_sel), .s0_dat_o(s0_dat_o),
        .s0_ack(s0_ack), .s0_stall(s0_stall),
        .s1_cyc(s1_cyc), .s1_stb(s1_stb), .s1_we(s1_we), .s1_adr(s1_adr),
        .s1_dat_i(s1_dat_i), .s1_sel(s1_sel), .s1_dat_o(s1_dat_o),
        .s1_ack(s1_ack), .s1_stall(s1_stall),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_o(m_dat_o), .m_sel(m_sel), .m_dat_i(m_dat_i), .m_ack(m_ack)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drop_all();
        s0_cyc = 1'b0; s0_stb = 1'b0; s0_we = 1'b0;
        s1_cyc = 1'b0; s1_stb = 1'b0; s1_we = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; m_ack = 1'b0; m_dat_i = '0;
        drop_all();
        s0_adr = '0; s0_dat_i = '0; s0_sel = '0;
        s1_adr = '0; s1_dat_i = '0; s1_sel = '0;
        tick(); tick();

        // Reset: outputs quiet even with a request and a stray m_ack present
        s0_cyc = 1'b1; s0_stb = 1'b1; m_ack = 1'b1;
        #1;
        check("rst_m_cyc",    64'(m_cyc),    0);
        check("rst_m_stb",    64'(m_stb),    0);
        check("rst_m_adr",    64'(m_adr),    0);
        check("rst_s0_stall", 64'(s0_stall), 0);
        check("rst_s0_ack",   64'(s0_ack),   0);
        check("rst_s0_dat",   s0_dat_o,      0);
        m_ack = 1'b0;
        drop_all();

        // Tie on the first cycle after reset, both held: grants alternate 0,1,0,1
        aresetn = 1'b1;
        s0_cyc = 1'b1; s0_stb = 1'b1; s0_adr = 29'h10;
        s1_cyc = 1'b1; s1_stb = 1'b1; s1_adr = 29'h20;
        for (int i = 0; i < 4; i++) begin
            logic exp_own;
            exp_own = (i % 2) == 1;
            tick();
            check("alt_adr", 64'(m_adr), exp_own ? 64'h20 : 64'h10);
            check("alt_stb", 64'(m_stb), 1);
            m_dat_i = 64'(i + 1); m_ack = 1'b1;
            #1;
            check("alt_ack0", 64'(s0_ack), 64'(!exp_own));
            check("alt_ack1", 64'(s1_ack), 64'(exp_own));
            check("alt_dat",  exp_own ? s1_dat_o : s0_dat_o, 64'(i + 1));
            check("alt_other_stall", 64'(exp_own ? s0_stall : s1_stall), 1);
            tick();
            m_ack = 1'b0;
            check("alt_gap_stb", 64'(m_stb), 0);
        end
        drop_all();
        tick();

        // s0 read at 0x100, response after 5 cycles
        s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_adr = 29'h100;
        #1;
        check("rd_stall_pre", 64'(s0_stall), 1);
        check("rd_stb_pre",   64'(m_stb),    0);
        tick();
        check("rd_stb",  64'(m_stb), 1);
        check("rd_cyc",  64'(m_cyc), 1);
        check("rd_adr",  64'(m_adr), 64'h100);
        check("rd_we",   64'(m_we),  0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rd_hold_stb", 64'(m_stb), 1);
            check("rd_no_ack",   64'(s0_ack), 0);
        end
        m_dat_i = 64'hDEADBEEF_01234567; m_ack = 1'b1;
        #1;
        check("rd_ack",       64'(s0_ack),   1);
        check("rd_dat",       s0_dat_o,      64'hDEADBEEF_01234567);
        check("rd_stall_ack", 64'(s0_stall), 0);
        check("rd_s1_ack",    64'(s1_ack),   0);
        check("rd_s1_dat",    s1_dat_o,      0);
        tick();
        m_ack = 1'b0; drop_all();
        check("rd_end_cyc", 64'(m_cyc),  0);
        check("rd_end_ack", 64'(s0_ack), 0);
        check("rd_end_dat", s0_dat_o,    0);

        // s1 write 0x55 / sel 0x0F held stable until m_ack
        s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b1; s1_adr = 29'h40;
        s1_dat_i = 64'h55; s1_sel = 8'h0F;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("wr_we",  64'(m_we),    1);
            check("wr_dat", m_dat_o,      64'h55);
            check("wr_sel", 64'(m_sel),   64'h0F);
            check("wr_adr", 64'(m_adr),   64'h40);
            check("wr_stb", 64'(m_stb),   1);
            tick();
        end
        m_dat_i = 64'h0; m_ack = 1'b1;
        #1;
        check("wr_ack",    64'(s1_ack), 1);
        check("wr_s0_ack", 64'(s0_ack), 0);
        tick();
        m_ack = 1'b0; drop_all();

        // s0 aborts in GRANT with s1 pending: drain, no ack, s1 granted at K+2
        s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_adr = 29'h200;
        s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b0; s1_adr = 29'h300;
        tick();
        check("dr_grant_adr", 64'(m_adr), 64'h200);
        tick();
        s0_cyc = 1'b0; s0_stb = 1'b0;
        tick();
        check("dr_stb", 64'(m_stb), 0);
        check("dr_cyc", 64'(m_cyc), 1);
        check("dr_s1_stall", 64'(s1_stall), 1);
        tick();
        check("dr_hold_cyc", 64'(m_cyc), 1);
        m_dat_i = 64'hAAAA_BBBB_CCCC_DDDD; m_ack = 1'b1;
        #1;
        check("dr_s0_ack", 64'(s0_ack), 0);
        check("dr_s1_ack", 64'(s1_ack), 0);
        check("dr_s0_dat", s0_dat_o,    0);
        tick();
        m_ack = 1'b0;
        check("dr_idle_cyc", 64'(m_cyc), 0);
        tick();
        check("dr_s1_stb", 64'(m_stb), 1);
        check("dr_s1_adr", 64'(m_adr), 64'h300);
        m_dat_i = 64'h1234; m_ack = 1'b1;
        #1;
        check("dr_s1_ack2", 64'(s1_ack), 1);
        check("dr_s1_dat2", s1_dat_o,    64'h1234);
        tick();
        m_ack = 1'b0; drop_all();

        // Reset in the middle of GRANT; afterwards a tie goes to s0
        s1_cyc = 1'b1; s1_stb = 1'b1; s1_we = 1'b1; s1_adr = 29'h500;
        s1_dat_i = 64'h77; s1_sel = 8'hFF;
        tick();
        check("mr_grant_stb", 64'(m_stb), 1);
        tick();
        aresetn = 1'b0; m_ack = 1'b1;
        #1;
        check("mr_s1_ack",   64'(s1_ack),   0);
        check("mr_s1_stall", 64'(s1_stall), 0);
        tick();
        m_ack = 1'b0;
        check("mr_cyc", 64'(m_cyc),   0);
        check("mr_stb", 64'(m_stb),   0);
        check("mr_we",  64'(m_we),    0);
        check("mr_adr", 64'(m_adr),   0);
        check("mr_dat", m_dat_o,      0);
        check("mr_sel", 64'(m_sel),   0);
        aresetn = 1'b1;
        s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_adr = 29'h600;
        tick();
        check("mr_tie_adr", 64'(m_adr), 64'h600);
        m_dat_i = 64'h9; m_ack = 1'b1;
        #1;
        check("mr_tie_ack", 64'(s0_ack), 1);
        tick();
        m_ack = 1'b0; drop_all();
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog: no response for 16 GRANT cycles gives an all-ones ack, then drain
        s0_cyc = 1'b1; s0_stb = 1'b1; s0_we = 1'b0; s0_adr = 29'h700;
        tick();
        for (int i = 1; i < 16; i++) begin
            check("to_wait_ack", 64'(s0_ack), 0);
            tick();
        end
        check("to_ack", 64'(s0_ack), 1);
        check("to_dat", s0_dat_o,    64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        drop_all();
        check("to_drain_stb", 64'(m_stb),  0);
        check("to_drain_cyc", 64'(m_cyc),  1);
        check("to_drain_ack", 64'(s0_ack), 0);
        m_dat_i = 64'h5A5A; m_ack = 1'b1;
        #1;
        check("to_late_ack", 64'(s0_ack), 0);
        tick();
        m_ack = 1'b0;
        check("to_end_cyc", 64'(m_cyc), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_bridge_arbiter.md
WB_BRIDGE_ARBITER -- requirements
Module: wb_bridge_arbiter

Interface
REQ-001 SHALL have parameter WB_ADR_WIDTH, default 29, word-address width of all Wishbone ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, data width; SEL_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only with WB_ARB_TIMEOUT_EN).
REQ-004 SHALL have port aclk  in  1  clock, all logic rising-edge.
REQ-005 SHALL have port aresetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have, for n in {0,1}: sn_cyc, sn_stb, sn_we  in  1 each  Wishbone B4 Classic slave-port request from requester n.
REQ-007 SHALL have, for n in {0,1}: sn_adr  in  WB_ADR_WIDTH;  sn_dat_i  in  DATA_WIDTH;  sn_sel  in  SEL_WIDTH.
REQ-008 SHALL have, for n in {0,1}: sn_dat_o  out  DATA_WIDTH;  sn_ack  out  1;  sn_stall  out  1.
REQ-009 SHALL have m_cyc, m_stb, m_we  out  1 each;  m_adr  out  WB_ADR_WIDTH;  m_dat_o  out  DATA_WIDTH;  m_sel  out  SEL_WIDTH  master port to the shared WB-to-AXI-Lite bridge.
REQ-010 SHALL have m_dat_i  in  DATA_WIDTH;  m_ack  in  1  bridge response (m_ack is a 1-cycle pulse).

Function
REQ-011 SHALL implement the states IDLE, GRANT and DRAIN.
REQ-012 IDLE: request n = sn_cyc & sn_stb; if one requests, grant it; if both request, grant the port not equal to last_grant; update last_grant; go to GRANT.
REQ-013 On grant SHALL register m_adr/m_we/m_dat_o/m_sel from the owner and assert m_cyc=m_stb=1 the next cycle (1-cycle arbitration latency).
REQ-014 GRANT: m_cyc/m_stb/m_* SHALL stay stable until m_ack.
REQ-015 In the cycle m_ack=1 in GRANT: owner ack = 1 and owner dat_o = m_dat_i (combinational); next state IDLE; m_cyc=m_stb=0 next cycle.
REQ-016 Non-owner sn_ack SHALL be 0 at all times; sn_dat_o SHALL be 0 when not acked.
REQ-017 sn_stall = sn_cyc & sn_stb & ~sn_ack.
REQ-018 Owner drops sn_cyc in GRANT before m_ack: go to DRAIN; m_stb=0, m_cyc held 1.
REQ-019 DRAIN: on m_ack, discard the response, give no sn_ack, go to IDLE.
REQ-020 m_ack in IDLE SHALL be ignored.
REQ-021 Earliest new grant after m_ack at cycle K: m_stb=1 at cycle K+2.

Reset
REQ-022 aresetn=0 SHALL force state IDLE and last_grant=1 (port 0 wins the first tie).
REQ-023 During reset, all m_* outputs, sn_ack, sn_stall and sn_dat_o SHALL be 0, and the timeout counter SHALL be 0.
REQ-024 Reset mid-transaction SHALL abandon it with no ack; the bridge shares aresetn.

Configuration
REQ-025 Macro WB_ARB_TIMEOUT_EN defined: a counter SHALL clear on entering GRANT and increment each GRANT cycle without m_ack.
REQ-026 With WB_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES-1 without m_ack, the owner SHALL get a 1-cycle ack with dat_o all ones, then go to DRAIN (m_stb=0, m_cyc=1).
REQ-027 With WB_ARB_TIMEOUT_EN, m_ack in the same cycle as the timeout SHALL win: a normal ack with data.
REQ-028 Without WB_ARB_TIMEOUT_EN: no counter; GRANT waits indefinitely; TIMEOUT_CYCLES unused.

Verification
REQ-029 Scenario: s0 read at adr 0x100, m_ack after 5 cycles with m_dat_i 0xDEADBEEF_01234567 -> m_stb rises 1 cycle after request; s0_ack pulses with that data; s1_ack stays 0.
REQ-030 Scenario: s0 and s1 both request on the first cycle after reset -> s0 served first, s1 next; with both held continuously, grants alternate 0,1,0,1.
REQ-031 Scenario: s1 write with data 0x55, sel 0x0F -> m_we=1, m_dat_o=0x55, m_sel=0x0F stable until m_ack.
REQ-032 Scenario: s0 drops cyc 2 cycles into GRANT -> DRAIN; the later m_ack gives no s0_ack; pending s1 granted 2 cycles later.
REQ-033 Scenario (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): no m_ack -> owner ack after 16 GRANT cycles with all-ones data; the late m_ack is discarded in DRAIN.
REQ-034 Scenario: assert aresetn=0 mid-GRANT -> all outputs 0 next cycle; a post-reset tie goes to s0.
